// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;
  localparam int CNT_W_PKG = 8;
  localparam logic [CNT_W_PKG-1:0] MIN_PER = CNT_W_PKG'(2);

  typedef struct packed {
    logic [CNT_W_PKG-1:0] per;
    logic [CNT_W_PKG-1:0] high;
  } ch_cfg_t;

  // High time clamped so every period keeps at least one low cycle.
  function automatic logic [CNT_W_PKG-1:0] high_eff(input ch_cfg_t c);
    return (c.high > c.per - 1'b1) ? c.per - 1'b1 : c.high;
  endfunction
endpackage

// File: rtl/prog_clk_div_ch.sv
// One divider channel: active/shadow config, pending bit, counter, registered outputs.
module prog_clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int RST_PER  = 4,
  parameter int RST_HIGH = 2
) (
  input  logic    clk_in,
  input  logic    rst,
  input  logic    en,
  input  logic    sync,
  input  logic    wr,
  input  ch_cfg_t wr_cfg,
  output logic    pending,
  output logic    clk_out,
  output logic    strobe
);
  localparam ch_cfg_t RST_CFG = '{per: CNT_W_PKG'(RST_PER), high: CNT_W_PKG'(RST_HIGH)};

  ch_cfg_t act_q, act_d, shd_q, shd_d;
  logic [CNT_W_PKG-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, bnd_q, bnd_d, clk_q, clk_d, stb_q, stb_d;
  logic on_now, on_nxt, boundary, restart;

  always_comb begin
    act_d    = act_q;
    shd_d    = shd_q;
    pend_d   = pend_q;
    bnd_d    = bnd_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    stb_d    = 1'b0;
    on_now   = (act_q.per >= MIN_PER);
    boundary = bnd_q || !on_now || (cnt_q == act_q.per - 1'b1);
    restart  = boundary || sync;
    on_nxt   = on_now;
    if (en) begin
      if (restart && pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      on_nxt = (act_d.per >= MIN_PER);
      cnt_d  = (restart || !on_nxt) ? '0 : cnt_q + 1'b1;
      clk_d  = on_nxt && (cnt_d < high_eff(act_d));
      stb_d  = on_nxt && (cnt_d == '0);
      bnd_d  = 1'b0;
    end
    // wr is only possible with pend_q clear, so it never collides with an apply.
    if (wr) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      act_q  <= RST_CFG;
      shd_q  <= RST_CFG;
      pend_q <= 1'b0;
      bnd_q  <= 1'b1;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      bnd_q  <= bnd_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      stb_q  <= stb_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_q;
  assign strobe  = stb_q;
endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: config decode, ready mux, channel array.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_PKG,
  parameter int RST_PER  = 4,
  parameter int RST_HIGH = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] strobe
);
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  ch_cfg_t           wr_cfg;

  assign wr_cfg    = '{per: cfg_period, high: cfg_high};
  assign cfg_ready = ~pend[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    prog_clk_div_ch #(
      .RST_PER  (RST_PER),
      .RST_HIGH (RST_HIGH)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .wr      (wr[i]),
      .wr_cfg  (wr_cfg),
      .pending (pend[i]),
      .clk_out (clk_out[i]),
      .strobe  (strobe[i])
    );
  end
endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div; expected waveforms queued per scenario.
module tb_prog_clk_div;
  logic       clk_in = 1'b0;
  logic       rst, en, sync, cfg_valid, cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period, cfg_high;
  logic [3:0] clk_out, strobe;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [7:0] vec_q[$];
  logic [1:0] e;
  logic [7:0] ev;

  prog_clk_div dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_out(clk_out), .strobe(strobe)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected {clk_out, strobe} k cycles after an aligned restart with
  // ch0 per3/high1, ch1 per5/high1, ch2 per6/high3, ch3 per4/high2.
  function automatic logic [7:0] exp_vec(input int k);
    logic [3:0] c, s;
    c[0] = (k % 3) < 1; s[0] = (k % 3) == 0;
    c[1] = (k % 5) < 1; s[1] = (k % 5) == 0;
    c[2] = (k % 6) < 3; s[2] = (k % 6) == 0;
    c[3] = (k % 4) < 2; s[3] = (k % 4) == 0;
    return {c, s};
  endfunction

  // Waits (bounded) for cfg_ready on the current cfg_ch to return high.
  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (cfg_ready === 1'b1) ok = 1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: cfg_ready stayed low past cycle budget", name);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_period = 0; cfg_high = 0;
    step(); step();
    n_cmp++; if (clk_out !== 4'h0) begin n_err++; $display("FAIL rst_clk: got %h want 0", clk_out); end
    n_cmp++; if (strobe !== 4'h0) begin n_err++; $display("FAIL rst_stb: got %h want 0", strobe); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", cfg_ready); end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(2'b11); exp_q.push_back(2'b10);
      exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[0], strobe[0]} !== e) begin
        n_err++; $display("FAIL defaults[%0d]: got %b want %b", i, {clk_out[0], strobe[0]}, e);
      end
    end
  endtask

  task automatic test_reprogram();
    step(); step();                         // ch1 now at cnt=1
    cfg_ch = 1; cfg_period = 5; cfg_high = 1; cfg_valid = 1;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reprog_rdy_pre: got %b want 1", cfg_ready); end
    step();
    cfg_valid = 0;
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(2'b11);
      repeat (4) exp_q.push_back(2'b00);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[1], strobe[1]} !== e) begin
        n_err++; $display("FAIL reprog[%0d]: got %b want %b", i, {clk_out[1], strobe[1]}, e);
      end
      if (i < 2) begin
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reprog_rdy_pend[%0d]: got %b want 0", i, cfg_ready); end
      end else if (i == 2) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reprog_rdy_post: got %b want 1", cfg_ready); end
      end
    end
  endtask

  task automatic test_clamp_off();
    cfg_ch = 2; cfg_period = 3; cfg_high = 7; cfg_valid = 1;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL clamp_rdy: got %b want 1", cfg_ready); end
    step(); cfg_valid = 0;
    wait_ready("clamp_apply");
    repeat (2) begin exp_q.push_back(2'b11); exp_q.push_back(2'b10); exp_q.push_back(2'b00); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[2], strobe[2]} !== e) begin
        n_err++; $display("FAIL clamp[%0d]: got %b want %b", i, {clk_out[2], strobe[2]}, e);
      end
    end
    cfg_period = 1; cfg_high = 0; cfg_valid = 1;
    step(); cfg_valid = 0;
    wait_ready("off_apply");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_cmp++;
      if ({clk_out[2], strobe[2]} !== 2'b00) begin
        n_err++; $display("FAIL off[%0d]: got %b want 00", i, {clk_out[2], strobe[2]});
      end
    end
    cfg_period = 6; cfg_high = 3; cfg_valid = 1;
    step(); cfg_valid = 0;
    #1;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL off_wr_rdy: got %b want 0", cfg_ready); end
    exp_q.push_back(2'b11); exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    repeat (3) exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    for (int i = 0; i < 7; i++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[2], strobe[2]} !== e) begin
        n_err++; $display("FAIL from_off[%0d]: got %b want %b", i, {clk_out[2], strobe[2]}, e);
      end
      if (i == 0) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL from_off_rdy: got %b want 1", cfg_ready); end
      end
    end
  endtask

  task automatic test_sync();
    cfg_ch = 0; cfg_period = 3; cfg_high = 1; cfg_valid = 1;
    step(); cfg_valid = 0;
    wait_ready("sync_prep");
    repeat ($urandom_range(1, 4)) step();
    sync = 1;
    step();
    sync = 0;
    for (int k = 0; k < 14; k++) vec_q.push_back(exp_vec(k));
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      ev = vec_q.pop_front();
      n_cmp++;
      if ({clk_out, strobe} !== ev) begin
        n_err++; $display("FAIL sync[k=%0d]: got %h want %h", k, {clk_out, strobe}, ev);
      end
    end
  endtask

  task automatic test_enable();
    // k=13: ch3 is mid-period at cnt=1
    en = 0;
    cfg_ch = 3; cfg_period = 2; cfg_high = 1; cfg_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      cfg_valid = 0;
      ev = exp_vec(13) & 8'hF0;
      n_cmp++;
      if ({clk_out, strobe} !== ev) begin
        n_err++; $display("FAIL freeze[%0d]: got %h want %h", i, {clk_out, strobe}, ev);
      end
    end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL freeze_wr_rdy: got %b want 0", cfg_ready); end
    en = 1;
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    exp_q.push_back(2'b11); exp_q.push_back(2'b00);
    exp_q.push_back(2'b11); exp_q.push_back(2'b00);
    for (int i = 0; i < 6; i++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[3], strobe[3]} !== e) begin
        n_err++; $display("FAIL resume[%0d]: got %b want %b", i, {clk_out[3], strobe[3]}, e);
      end
    end
  endtask

  task automatic test_reset_pending();
    cfg_ch = 2; cfg_period = 9; cfg_high = 4; cfg_valid = 1;
    step(); cfg_valid = 0;
    #1;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rstp_pend: got %b want 0", cfg_ready); end
    rst = 1;
    step();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rstp_rdy: got %b want 1", cfg_ready); end
    n_cmp++; if ({clk_out, strobe} !== 8'h00) begin n_err++; $display("FAIL rstp_out: got %h want 00", {clk_out, strobe}); end
    rst = 0;
    repeat (2) begin
      exp_q.push_back(2'b11); exp_q.push_back(2'b10);
      exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({clk_out[2], strobe[2]} !== e) begin
        n_err++; $display("FAIL rstp_run[%0d]: got %b want %b", i, {clk_out[2], strobe[2]}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reprogram();
    test_clamp_off();
    test_sync();
    test_enable();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
